// File: rtl/adder_seq_ctrl_if.sv
// Requester and result handshake bundle for the byte-serial add/subtract controller.
// The master side issues operations and consumes results; the slave side is the controller.
interface adder_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_sub;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_sub;

    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_sum, res_cout, res_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_sum, res_cout, res_ovf
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Byte-serial add/subtract controller sharing one 8-bit carry-lookahead adder
// between two requesters through a round-robin arbiter, with a backpressured result port.

module adder_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pp;

    // Each carry is a flat sum of generate terms gated by propagate products.
    always_comb begin
        g   = a & b;
        p   = a ^ b;
        c   = '0;
        acc = 1'b0;
        pp  = 1'b0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc = acc | (pp & ci);
            c[i+1] = acc;
        end
        s  = p ^ c[7:0];
        co = c[8];
    end
endmodule

module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    adder_seq_ctrl_if.slave   bus,
    output logic [1:0]        state_dbg
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            gnt0;
    logic            gnt1;
    logic            accept;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_beff;
    logic            sel_sub;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    res_sum_q;
    logic            res_id_q;
    logic            last;
    logic            a_msb;
    logic            b_msb;

    logic [7:0]      add_s;
    logic            add_co;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid may not depend on ready, and the initiator holds its payload until that edge.

    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || last);
        gnt1 = bus.req1_valid && !gnt0;
    end

    assign accept = (state == IDLE) && (gnt0 || gnt1);

    always_comb begin
        sel_a    = gnt1 ? bus.req1_a : bus.req0_a;
        sel_sub  = gnt1 ? bus.req1_sub : bus.req0_sub;
        sel_beff = gnt1 ? bus.req1_b : bus.req0_b;
        if (sel_sub) begin
            sel_beff = ~sel_beff;
        end
    end

    adder_8_bit u_adder (
        .a  (a_q[idx*8 +: 8]),
        .b  (b_q[idx*8 +: 8]),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = (state == IDLE) && gnt0;
        bus.req1_ready = (state == IDLE) && gnt1;
        bus.res_valid  = (state == DONE);
        bus.res_cout   = (state == DONE) && carry;
        bus.res_ovf    = (state == DONE) && (a_msb == b_msb) && (res_sum_q[W-1] != a_msb);
        bus.res_id     = res_id_q;
        bus.res_sum    = res_sum_q;
        state_dbg      = state;
    end

    // Subtraction is a + ~b + 1, so the carry-in is seeded with the sub flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            res_sum_q <= '0;
            res_id_q  <= 1'b0;
            last      <= 1'b1;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else if (accept) begin
            a_q      <= sel_a;
            b_q      <= sel_beff;
            carry    <= sel_sub;
            idx      <= '0;
            res_id_q <= gnt1;
            last     <= gnt1;
            a_msb    <= sel_a[W-1];
            b_msb    <= sel_beff[W-1];
        end else if (state == RUN) begin
            res_sum_q[idx*8 +: 8] <= add_s;
            carry                 <= add_co;
            idx                   <= idx + 1'b1;
        end
    end
endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Byte-serial add/subtract controller for the K-means accelerator. It time-shares one internal `adder_8_bit` carry-lookahead instance between two requesters: the distance unit (requester 0) and the centroid-update unit (requester 1). Each operation processes an NBYTES-wide operand pair one byte per cycle, LSB first, with the carry registered between bytes. A round-robin arbiter grants the adder, and a valid/ready result port supports backpressure.

## Interface
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..16
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_a, req0_b  in  W each  requester 0 operands (unsigned / two's complement)
- req0_sub  in  1  requester 0: 1 = a−b, 0 = a+b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0, for requester 1
- res_valid  out  1  result held and valid
- res_ready  in  1  consumer accepts result
- res_id  out  1  requester that issued the result
- res_sum  out  W  result, modulo 2^W
- res_cout  out  1  carry out of MSB byte; for subtract, 1 = no borrow (a ≥ b unsigned)
- res_ovf  out  1  signed two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - Grant is combinational.
  - Only one valid requester: that requester wins.
  - Both valid: the requester other than `last` wins (`last` resets to 1, so requester 0 wins the first tie).
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high at a time.
- Acceptance (valid && ready at an edge)
  - Latch a, and effective b = sub ? ~b : b.
  - carry ← sub.
  - Byte index ← 0.
  - res_id ← N; last ← N.
  - Capture the MSB of a and of effective b for the overflow check.
  - Go to RUN.
- RUN, per cycle
  - Adder inputs: a byte[idx], effective-b byte[idx], ci = carry.
  - Store the sum into res_sum byte[idx]; carry ← c0; idx++.
  - When the edge processes idx == NBYTES−1, go to DONE.
- DONE
  - res_valid = 1; res_cout = final carry.
  - res_ovf = (a_msb == beff_msb) && (res_sum[W−1] != a_msb).
  - On res_valid && res_ready, go to IDLE.
- Both ready outputs are low in RUN and DONE. Requests are never dropped; a requester holds its inputs until accepted.
- Operand inputs are sampled only at acceptance. Changes afterwards do not affect the operation in flight.

## Timing
- Reset values: state IDLE, req0_ready/req1_ready driven by the IDLE grant logic, res_valid 0, res_id 0, res_sum 0, res_cout 0, res_ovf 0, last 1, carry 0, idx 0.
- Latency: accept at edge k; bytes 0..NBYTES−1 are processed at edges k+1..k+NBYTES; res_valid is high from edge k+NBYTES.
- Throughput: with res_ready held high, one operation per NBYTES+2 cycles (RUN ×NBYTES, DONE ×1, IDLE ×1).
- Backpressure: in DONE with res_ready low, res_valid, res_sum, res_id, res_cout and res_ovf hold stable indefinitely.
- res_sum bytes are updated progressively during RUN. Consumers use them only when res_valid is high.
- Simultaneous requests: the arbiter alternates strictly when both requesters are continuously valid. The `last` pointer updates only on acceptance.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The in-flight result is discarded and no res_valid pulse is produced. The first operation after reset is processed correctly.
- Wrap-around: results are modulo 2^W; cout and ovf report the wrap.

## Test plan
All scenarios use NBYTES=4.
1. req0 add 0x000000FF + 0x00000001 → res_sum 0x00000100, cout 0, ovf 0, res_id 0, res_valid exactly 4 edges after acceptance.
2. req1 add 0xFFFFFFFF + 0x00000001 → res_sum 0x00000000, cout 1, ovf 0. Also 0x7FFFFFFF + 1 → 0x80000000, cout 0, ovf 1.
3. Subtract: 5 − 7 → 0xFFFFFFFE, cout 0, ovf 0; 7 − 5 → 0x00000002, cout 1; 0x80000000 − 1 → 0x7FFFFFFF, ovf 1.
4. Both requesters valid continuously for 6 operations with res_ready=1 → res_id sequence 0,1,0,1,0,1, one result every 6 cycles, ready never high on both.
5. Hold res_ready low for 10 cycles in DONE → result fields stable, both readies low, no new acceptance; result consumed and IDLE entered one edge after res_ready rises.
6. Assert rst for 1 cycle during RUN byte 2 → res_valid stays 0, outputs at reset values; a following 0x12345678 + 0x11111111 → 0x23456789, cout 0.
